// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Round-robin arbiter that shares the single write port of the register file
//   among NREQ write-back sources. It also keeps a pending-write scoreboard so
//   issue logic can stall on RAW hazards.
//
//   Optional feature macro: RF_WB_FWD_EN
//     When defined, adds a combinational forwarding path. The path exposes the
//     registered write that is in flight this cycle to two read ports.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   [NREQ]       requester i has a write pending (held until ready)
//   req_addr    [NREQ*AW]    dest register of requester i, slice [i*AW +: AW]
//   req_data    [NREQ*DW]    write data of requester i, slice [i*DW +: DW]
//   req_ready   [NREQ]       one-hot grant, combinational
//   pend_set    mark pend_addr as awaiting write-back
//   pend_addr   [AW]         register to mark pending
//   pend_mask   [2**AW]      bit r set while register r awaits write-back
//   rf_we       registered write enable to reg_file
//   rf_waddr    [AW]         registered write address to reg_file
//   rf_wdata    [DW]         registered write data to reg_file
//   fwd_raddr1/2 [AW]  (RF_WB_FWD_EN only) read addresses to compare
//   fwd_hit1/2         (RF_WB_FWD_EN only) in-flight write matches read
//   fwd_data1/2 [DW]   (RF_WB_FWD_EN only) forwarded data, 0 when no hit
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 pend_set,
    input  logic [AW-1:0]        pend_addr,
    output logic [(2**AW)-1:0]   pend_mask,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata
`ifdef RF_WB_FWD_EN
    ,
    input  logic [AW-1:0]        fwd_raddr1,
    input  logic [AW-1:0]        fwd_raddr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DW-1:0]        fwd_data1,
    output logic [DW-1:0]        fwd_data2
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NR = 2**AW;

    // Round-robin pointer: index of the requester with highest priority.
    logic [PW-1:0] ptr_q, ptr_d;

    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [NR-1:0] pend_q, pend_d;

    logic          grant_any;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;

    // Round-robin search: the first valid requester found at or after the pointer
    // wins. The search wraps modulo NREQ.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        req_ready = '0;
        grant_any = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (grant_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data = req_data[int'(gnt_idx)*DW +: DW];

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;

        if (grant_any) begin
            ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            // A write to x0 is accepted but never reaches the register file.
            we_d    = (gnt_addr != '0);
            waddr_d = gnt_addr;
            wdata_d = gnt_data;
            pend_d[gnt_addr] = 1'b0;
        end

        // The set is applied after the clear, so a producer newly issued for the
        // same register keeps it pending.
        if (pend_set) begin
            pend_d[pend_addr] = 1'b1;
        end

        // x0 is hardwired zero and never pending.
        pend_d[0] = 1'b0;
    end

    // NOTE: the scoreboard is control state (not a data array), so it is reset
    //       along with the other registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from the
            //       same pre-edge values.
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign pend_mask = pend_q;

`ifdef RF_WB_FWD_EN
    // Zero-latency bypass of the write the register file commits this cycle.
    assign fwd_hit1  = we_q && (waddr_q == fwd_raddr1) && (fwd_raddr1 != '0);
    assign fwd_hit2  = we_q && (waddr_q == fwd_raddr2) && (fwd_raddr2 != '0);
    assign fwd_data1 = fwd_hit1 ? wdata_q : '0;
    assign fwd_data2 = fwd_hit2 ? wdata_q : '0;
`endif

endmodule
